// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core pipeline control logic: controller state
// encoding, the NOP instruction word and the architectural register-index width.
package core_ctrl_pkg;

   localparam int REG_AW = 3;

   localparam logic [15:0] NOP_INSTR = 16'h0000;

   typedef enum logic {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } ctrl_state_e;

endpackage : core_ctrl_pkg

// File: rtl/hazard_detect_unit.sv
// Combinational load-use comparator: flags an ID instruction that reads the
// destination of a load currently in EX. Register 0 never creates a hazard.
module hazard_detect_unit #(
   parameter int REG_AW = 3
) (
   input  logic              ex_memread_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_use_rs_i,
   input  logic              id_use_rt_i,
   output logic              load_use_o
);

   logic rs_match;
   logic rt_match;

   assign rs_match   = id_use_rs_i && (id_rs_i == ex_rd_i);
   assign rt_match   = id_use_rt_i && (id_rt_i == ex_rd_i);
   assign load_use_o = ex_memread_i && (ex_rd_i != '0) && (rs_match || rt_match);

endmodule : hazard_detect_unit

// File: rtl/pc_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage core: load-use bubbles, taken-branch
// flushes and multi-cycle MDU stalls with a timeout watchdog and stall counter.
module pc_hazard_ctrl #(
   parameter int REG_AW      = 3,
   parameter int MDU_TIMEOUT = 64,
   parameter int CNT_W       = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic              id_use_rs_i,
   input  logic              id_use_rt_i,
   input  logic              ex_memread_i,
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              ex_branch_taken_i,
   input  logic              ex_mdu_start_i,
   input  logic              mdu_done_i,
   output logic              pc_stall_o,
   output logic              ifid_stall_o,
   output logic              ifid_flush_o,
   output logic              idex_stall_o,
   output logic              idex_flush_o,
   output logic              exmem_bubble_o,
   output logic              err_timeout_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   import core_ctrl_pkg::*;

   localparam int TO_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(MDU_TIMEOUT - 1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (c == '1) ? c : c + CNT_W'(1);
   endfunction

   ctrl_state_e       state_q, state_d;
   logic [TO_W-1:0]   tmo_q, tmo_d;
   logic              err_q, err_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic load_use;
   logic timeout_hit;
   logic mdu_busy;

   hazard_detect_unit #(
      .REG_AW (REG_AW)
   ) u_hdu (
      .ex_memread_i (ex_memread_i),
      .ex_rd_i      (ex_rd_i),
      .id_rs_i      (id_rs_i),
      .id_rt_i      (id_rt_i),
      .id_use_rs_i  (id_use_rs_i),
      .id_use_rt_i  (id_use_rt_i),
      .load_use_o   (load_use)
   );

   assign timeout_hit = (state_q == MDU_WAIT) && (tmo_q == TO_LAST);

   always_comb begin
      state_d        = state_q;
      err_d          = err_q;
      tmo_d          = '0;
      mdu_busy       = 1'b0;
      pc_stall_o     = 1'b0;
      ifid_stall_o   = 1'b0;
      ifid_flush_o   = 1'b0;
      idex_stall_o   = 1'b0;
      idex_flush_o   = 1'b0;
      exmem_bubble_o = 1'b0;

      unique case (state_q)
         RUN: begin
            mdu_busy = ex_mdu_start_i && !mdu_done_i;
            if (mdu_busy) begin
               state_d = MDU_WAIT;
            end
         end
         MDU_WAIT: begin
            tmo_d    = tmo_q + TO_W'(1);
            mdu_busy = !mdu_done_i && !timeout_hit;
            if (mdu_done_i || timeout_hit) begin
               state_d = RUN;
            end
            if (timeout_hit && !mdu_done_i) begin
               err_d = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase

      // Branch and load-use are only meaningful while running; MDU stall dominates.
      if (rst_i) begin
         pc_stall_o = 1'b0;
      end else if (mdu_busy) begin
         pc_stall_o     = 1'b1;
         ifid_stall_o   = 1'b1;
         idex_stall_o   = 1'b1;
         exmem_bubble_o = 1'b1;
      end else if (state_q == RUN && ex_branch_taken_i) begin
         ifid_flush_o = 1'b1;
         idex_flush_o = 1'b1;
      end else if (state_q == RUN && load_use) begin
         pc_stall_o   = 1'b1;
         ifid_stall_o = 1'b1;
         idex_flush_o = 1'b1;
      end

      cnt_d = pc_stall_o ? sat_inc(cnt_q) : cnt_q;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= RUN;
         tmo_q   <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign err_timeout_o = err_q;
   assign stall_cnt_o   = cnt_q;

endmodule : pc_hazard_ctrl

// File: tb/tb_pc_hazard_ctrl.sv
// Scoreboard bench for pc_hazard_ctrl: directed per-cycle vectors push expected
// outputs, a monitor pops and compares them on the falling clock edge.
module tb_pc_hazard_ctrl;

   localparam int REG_AW = 3;
   localparam int CNT_W  = 16;

   // ctl bits: pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble
   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] LU   = 6'b110010;
   localparam logic [5:0] BR   = 6'b001010;
   localparam logic [5:0] MDU  = 6'b110101;

   typedef struct {
      string       name;
      logic [5:0]  ctl;
      logic        err;
      int          cnt;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [REG_AW-1:0] id_rs = '0, id_rt = '0, ex_rd = '0;
   logic              use_rs = 1'b0, use_rt = 1'b0, memread = 1'b0;
   logic              br = 1'b0, start = 1'b0, done = 1'b0;
   logic              pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble;
   logic              err_timeout;
   logic [CNT_W-1:0]  stall_cnt;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   stim_done = 1'b0;

   pc_hazard_ctrl #(
      .REG_AW      (REG_AW),
      .MDU_TIMEOUT (8),
      .CNT_W       (CNT_W)
   ) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .id_rs_i           (id_rs),
      .id_rt_i           (id_rt),
      .id_use_rs_i       (use_rs),
      .id_use_rt_i       (use_rt),
      .ex_memread_i      (memread),
      .ex_rd_i           (ex_rd),
      .ex_branch_taken_i (br),
      .ex_mdu_start_i    (start),
      .mdu_done_i        (done),
      .pc_stall_o        (pc_stall),
      .ifid_stall_o      (ifid_stall),
      .ifid_flush_o      (ifid_flush),
      .idex_stall_o      (idex_stall),
      .idex_flush_o      (idex_flush),
      .exmem_bubble_o    (exmem_bubble),
      .err_timeout_o     (err_timeout),
      .stall_cnt_o       (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic cyc(input string nm, input bit r, input bit mr, input int rd,
                      input int rs, input bit urs, input int rt, input bit urt,
                      input bit b, input bit st, input bit dn,
                      input logic [5:0] ctl, input bit e, input int cnt);
      exp_t x;
      @(posedge clk);
      #1;
      rst = r; memread = mr; ex_rd = REG_AW'(rd);
      id_rs = REG_AW'(rs); use_rs = urs; id_rt = REG_AW'(rt); use_rt = urt;
      br = b; start = st; done = dn;
      x.name = nm; x.ctl = ctl; x.err = e; x.cnt = cnt;
      sb.push_back(x);
   endtask

   task automatic idle(input string nm, input logic [5:0] ctl, input bit e, input int cnt);
      cyc(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ctl, e, cnt);
   endtask

   // Monitor
   initial begin
      exp_t x;
      logic [5:0] act;
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            x   = sb.pop_front();
            act = {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_bubble};
            n_cmp++;
            if (act !== x.ctl) begin
               n_bad++;
               $display("FAIL %s ctl: got %b expected %b", x.name, act, x.ctl);
            end
            n_cmp++;
            if (err_timeout !== x.err) begin
               n_bad++;
               $display("FAIL %s err_timeout: got %b expected %b", x.name, err_timeout, x.err);
            end
            n_cmp++;
            if (stall_cnt !== CNT_W'(x.cnt)) begin
               n_bad++;
               $display("FAIL %s stall_cnt: got %0d expected %0d", x.name, stall_cnt, x.cnt);
            end
         end
      end
   end

   // Stimulus: name, rst, memread, rd, rs, use_rs, rt, use_rt, br, start, done | ctl, err, cnt
   initial begin
      cyc("rst_gate_lu",  1, 1, 3, 3, 1, 0, 0, 0, 0, 0, NONE, 0, 0);
      cyc("rst_gate_mdu", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, NONE, 0, 0);
      idle("idle0", NONE, 0, 0);
      cyc("lu_rs",        0, 1, 3, 3, 1, 0, 0, 0, 0, 0, LU,   0, 0);
      idle("lu_after", NONE, 0, 1);
      cyc("lu_r0",        0, 1, 0, 0, 1, 0, 0, 0, 0, 0, NONE, 0, 1);
      cyc("lu_unused",    0, 1, 3, 3, 0, 0, 0, 0, 0, 0, NONE, 0, 1);
      cyc("lu_noload",    0, 0, 3, 3, 1, 0, 0, 0, 0, 0, NONE, 0, 1);
      cyc("lu_rt",        0, 1, 5, 1, 1, 5, 1, 0, 0, 0, LU,   0, 1);
      idle("lu_rt_after", NONE, 0, 2);
      cyc("br_lu",        0, 1, 3, 3, 1, 0, 0, 1, 0, 0, BR,   0, 2);
      idle("br_after", NONE, 0, 2);
      // 5-cycle MDU operation
      cyc("mdu_start",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MDU,  0, 2);
      idle("mdu_w1", MDU, 0, 3);
      cyc("mdu_w2_brlu",  0, 1, 3, 3, 1, 0, 0, 1, 0, 0, MDU,  0, 4);
      idle("mdu_w3", MDU, 0, 5);
      idle("mdu_w4", MDU, 0, 6);
      cyc("mdu_done",     0, 1, 3, 3, 1, 0, 0, 1, 0, 1, NONE, 0, 7);
      cyc("run_lu",       0, 1, 2, 0, 0, 2, 1, 0, 0, 0, LU,   0, 7);
      idle("run_idle", NONE, 0, 8);
      cyc("mdu_1cyc",     0, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 0, 8);
      cyc("br_run",       0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR,   0, 8);
      // Timeout: start + 7 stalled wait cycles, release at count 7
      cyc("to_start",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MDU,  0, 8);
      for (int i = 0; i < 7; i++) idle($sformatf("to_w%0d", i), MDU, 0, 9 + i);
      idle("to_release", NONE, 0, 16);
      cyc("to_err_br",    0, 0, 0, 0, 0, 0, 0, 1, 0, 0, BR,   1, 16);
      idle("to_err_hold", NONE, 1, 16);
      // Reset during MDU_WAIT (third stall cycle)
      cyc("rm_start",     0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MDU,  1, 16);
      idle("rm_w1", MDU, 1, 17);
      cyc("rm_rst",       1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 1, 18);
      idle("rm_after", NONE, 0, 0);
      cyc("rm_lu",        0, 1, 4, 4, 1, 0, 0, 0, 0, 0, LU,   0, 0);
      idle("rm_final", NONE, 0, 1);
      stim_done = 1'b1;
   end

   initial begin
      int guard = 0;
      while (!(stim_done && sb.size() == 0) && guard < 2000) begin
         @(posedge clk);
         guard++;
      end
      if (guard >= 2000) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: scoreboard left %0d entries, required 0", sb.size());
      end
      @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_pc_hazard_ctrl
